prv664_regfile_lvt: RTL and testbench
=====================================

Name: prv664_regfile_lvt

Overview:
- Parametrised multi-port integer/FP register file for the dispatch stage.
- Uses a Live Value Table (LVT) over NW banks. Each bank has one write port and one async-read copy per read port, so it maps onto FPGA distributed RAM.
- Adds three things to the fixed 4r2w file: a post-reset zeroing state machine, optional write-to-read bypass, and a handshaked debug read/write port for use while the core is halted.

Parameters:
- DATA_WIDTH, 64, register width in bits
- DEPTH, 32, number of architectural registers (power of 2, minimum 2)
- NR, 4, number of pipeline read ports
- NW, 2, number of commit write ports (minimum 1)
- ZERO_REG, 1, when 1: index 0 always reads 0 and writes to index 0 are discarded
- BYPASS, 0, when 1: a read of an index written this cycle returns the incoming write data
- Derived: IW = $clog2(DEPTH); LW = (NW>1) ? $clog2(NW) : 1

Ports:
- clk_i  in  1  clock
- arst_i  in  1  asynchronous active-high reset
- rd_index_i  in  NR*IW  read indices; port r uses bits [r*IW +: IW]
- rd_data_o  out  NR*DATA_WIDTH  async read data, port r slice
- wr_valid_i  in  NW  commit write enables
- wr_index_i  in  NW*IW  write indices
- wr_data_i  in  NW*DATA_WIDTH  write data
- init_done_o  out  1  high once zeroing completes
- halted_i  in  1  pipeline halted; debug accesses are allowed only when high
- dbg_req_i  in  1  debug request; held high until dbg_ack_o
- dbg_we_i  in  1  1 = write, 0 = read
- dbg_index_i  in  IW  debug register index
- dbg_wdata_i  in  DATA_WIDTH  debug write data
- dbg_ack_o  out  1  one-cycle completion pulse
- dbg_rdata_o  out  DATA_WIDTH  registered debug read data, valid with dbg_ack_o
- wr_drop_o  out  1  pulses when a commit write is discarded (during INIT, or when displaced by a debug write)

Behaviour:
- Reset values: LVT all 0, FSM = INIT, init counter = 0, init_done_o = 0, dbg_ack_o = 0, dbg_rdata_o = 0, wr_drop_o = 0.
- Memory contents are not reset; the INIT state machine clears them.
- FSM INIT:
  - Each cycle writes 0 into bank 0 at the counter address, sets LVT[counter] = 0, and increments the counter.
  - After writing DEPTH-1 it moves to RUN on the next edge, so INIT lasts exactly DEPTH cycles.
  - During INIT: all rd_data_o read 0, commit writes are discarded (wr_drop_o = 1 if any wr_valid_i), and dbg_req_i is not acknowledged.
- FSM RUN: init_done_o = 1. The FSM stays in RUN until arst_i; an asserted arst_i at any point returns it to INIT.
- Commit write w: bank w is written at wr_index_i[w]; LVT[index] <= w on the clock edge.
- Same-index writes in one cycle: all banks are written, and the LVT takes the highest-numbered valid port, so the highest port wins.
- Read port r: rd_data_o[r] = bank[LVT[idx]] copy r. This is combinational from rd_index_i, with zero cycles of latency.
- Read-after-write: without bypass, data written at edge N is visible after edge N.
- With BYPASS = 1: if any valid write (highest port wins) targets idx in the same cycle, that write data is returned instead.
- ZERO_REG = 1:
  - Reads of index 0 return 0 on every port, including debug.
  - Writes to index 0 change neither the banks' LVT entry nor cause a drop pulse.
- Debug port:
  - Sampled only in RUN with halted_i = 1 and dbg_ack_o = 0.
  - Read: dbg_rdata_o <= current value of dbg_index_i (through a dedicated read copy per bank, i.e. NR+1 copies). dbg_ack_o = 1 on the following cycle.
  - Write: performed through bank 0 on the sampling edge with LVT[idx] <= 0. This overrides commit port 0 in that cycle; if wr_valid_i[0] was high, that write is discarded and wr_drop_o = 1. Other ports still write; a higher port writing the same index still wins the LVT. dbg_ack_o = 1 on the next cycle.
  - The requester keeps dbg_req_i high until the ack. A new request is sampled no earlier than the cycle after the ack (one outstanding access, max one access per 2 cycles).
  - If halted_i drops while a request is pending, the request is not sampled and no ack is issued.
- Reset mid-access: a pending ack is cancelled and init restarts.

Test Plan:
- Zeroing: release reset, drive wr_valid all ones during INIT -> init_done_o rises exactly DEPTH = 32 cycles later; all reads return 0 throughout; wr_drop_o stays high during INIT.
- Dual-write conflict: wr port0 idx 5 = 0xAAAA and port1 idx 5 = 0xBBBB in the same cycle -> all ports read 0xBBBB at idx 5. Next cycle port0 writes 0xCCCC -> reads 0xCCCC.
- Zero register: write 0x1234 to idx 0 on every port -> reads of idx 0 return 0 on every port and the debug port.
- Bypass: BYPASS = 1, write 0xDEAD to idx 7 while reading idx 7 -> same-cycle read returns 0xDEAD. With BYPASS = 0 the read returns the old value (0).
- Debug: halted_i = 1, debug write idx 3 = 0x55 concurrent with port0 write idx 9 -> ack after 1 cycle, wr_drop_o pulses, idx 9 unchanged. Then debug read idx 3 -> dbg_rdata_o = 0x55 with ack.
- Reset mid-debug: assert arst_i the cycle after a debug request -> no ack issued, init_done_o = 0, and INIT restarts at index 0.

Source files
------------

// File: rtl/prv664_regfile_lvt.sv
// -----------------------------------------------------------------------------
// prv664_regfile_lvt
//
// Multi-port integer/FP register file for the dispatch stage, built from NW
// single-write banks arbitrated by a Live Value Table (LVT). Each bank keeps
// NR+1 asynchronously read copies (one per pipeline read port plus one for the
// debug port), so every copy maps onto a 1W1R distributed RAM.
//
// After reset an INIT state machine zeroes the file through bank 0, one entry
// per cycle. A handshaked debug port gives read/write access while the core is
// halted.
//
// Ports
//   clk_i        clock
//   arst_i       asynchronous active-high reset
//   rd_index_i   NR packed read indices, port r = [r*IW +: IW]
//   rd_data_o    NR packed read data, combinational from rd_index_i
//   wr_valid_i   NW commit write enables
//   wr_index_i   NW packed write indices
//   wr_data_i    NW packed write data
//   init_done_o  high once the zeroing pass has finished
//   halted_i     core halted, debug accesses permitted
//   dbg_req_i    debug request, held until dbg_ack_o
//   dbg_we_i     debug direction (1 = write)
//   dbg_index_i  debug register index
//   dbg_wdata_i  debug write data
//   dbg_ack_o    one-cycle completion pulse
//   dbg_rdata_o  registered debug read data, valid with dbg_ack_o
//   wr_drop_o    registered pulse, a commit write was discarded last cycle
// -----------------------------------------------------------------------------
module prv664_regfile_lvt #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 32,
  parameter int NR         = 4,
  parameter int NW         = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 0,
  localparam int IW        = $clog2(DEPTH),
  localparam int LW        = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  input  logic [NR*IW-1:0]           rd_index_i,
  output logic [NR*DATA_WIDTH-1:0]   rd_data_o,
  input  logic [NW-1:0]              wr_valid_i,
  input  logic [NW*IW-1:0]           wr_index_i,
  input  logic [NW*DATA_WIDTH-1:0]   wr_data_i,
  output logic                       init_done_o,
  input  logic                       halted_i,
  input  logic                       dbg_req_i,
  input  logic                       dbg_we_i,
  input  logic [IW-1:0]              dbg_index_i,
  input  logic [DATA_WIDTH-1:0]      dbg_wdata_i,
  output logic                       dbg_ack_o,
  output logic [DATA_WIDTH-1:0]      dbg_rdata_o,
  output logic                       wr_drop_o
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  state_e                 r_state;
  logic [IW-1:0]          r_init_cnt;
  logic                   r_dbg_ack;
  logic [DATA_WIDTH-1:0]  r_dbg_rdata;
  logic                   r_wr_drop;
  logic [LW-1:0]          r_lvt [DEPTH];

  // Effective per-bank write port after INIT / debug / zero-register steering.
  logic [NW-1:0]          w_bank_we;
  logic [IW-1:0]          w_bank_addr [NW];
  logic [DATA_WIDTH-1:0]  w_bank_data [NW];

  // Read address per copy: copies 0..NR-1 serve the pipeline, copy NR the debug port.
  logic [IW-1:0]          w_rd_addr [NR+1];
  logic [DATA_WIDTH-1:0]  w_bank_rd [NW][NR+1];
  logic [DATA_WIDTH-1:0]  w_rd_val  [NR+1];

  logic                   w_dbg_fire;
  logic                   w_dbg_wr;
  logic                   w_dbg_rd;
  logic                   w_wr_drop;

  function automatic logic is_zero_idx(input logic [IW-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

  // A debug access is taken only in RUN, while halted, and never in the
  // ack cycle, which limits the port to one access every two cycles.
  assign w_dbg_fire = (r_state == S_RUN) && halted_i && dbg_req_i && !r_dbg_ack;
  assign w_dbg_wr   = w_dbg_fire && dbg_we_i;
  assign w_dbg_rd   = w_dbg_fire && !dbg_we_i;

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path through the block leaves a value held (no latch).
  always_comb begin
    w_bank_we = '0;
    for (int b = 0; b < NW; b++) begin
      w_bank_addr[b] = wr_index_i[b*IW +: IW];
      w_bank_data[b] = wr_data_i[b*DATA_WIDTH +: DATA_WIDTH];
    end

    if (r_state == S_INIT) begin
      // Zeroing pass owns bank 0; commit writes are dropped.
      w_bank_we[0]   = 1'b1;
      w_bank_addr[0] = r_init_cnt;
      w_bank_data[0] = '0;
    end else begin
      for (int b = 0; b < NW; b++) begin
        w_bank_we[b] = wr_valid_i[b] && !is_zero_idx(w_bank_addr[b]);
      end
      // Debug writes borrow bank 0, displacing commit port 0.
      if (w_dbg_wr) begin
        w_bank_we[0]   = !is_zero_idx(dbg_index_i);
        w_bank_addr[0] = dbg_index_i;
        w_bank_data[0] = dbg_wdata_i;
      end
    end
  end

  // Port 0's displaced write only counts as a drop if it would have landed;
  // writes to the hard-wired zero register are silently ignored.
  assign w_wr_drop = ((r_state == S_INIT) && (|wr_valid_i)) ||
                     (w_dbg_wr && wr_valid_i[0] && !is_zero_idx(wr_index_i[0 +: IW]));

  always_comb begin
    for (int c = 0; c < NR; c++) begin
      w_rd_addr[c] = rd_index_i[c*IW +: IW];
    end
    w_rd_addr[NR] = dbg_index_i;
  end

  for (genvar b = 0; b < NW; b++) begin : g_bank
    for (genvar c = 0; c <= NR; c++) begin : g_copy
      logic [DATA_WIDTH-1:0] r_mem [DEPTH];

      // NOTE: the RAM has no reset so it can map onto distributed memory; the
      // INIT pass and the LVT reset together give it a defined state.
      always_ff @(posedge clk_i) begin
        if (w_bank_we[b]) begin
          r_mem[w_bank_addr[b]] <= w_bank_data[b];
        end
      end

      assign w_bank_rd[b][c] = r_mem[w_rd_addr[c]];
    end
  end

  // Read mux: LVT picks the bank holding the live value, then optional
  // same-cycle bypass (pipeline copies only), then the INIT / zero overrides.
  always_comb begin
    for (int c = 0; c <= NR; c++) begin
      w_rd_val[c] = '0;
      for (int b = 0; b < NW; b++) begin
        if (r_lvt[w_rd_addr[c]] == LW'(b)) begin
          w_rd_val[c] = w_bank_rd[b][c];
        end
      end
      if ((BYPASS != 0) && (c < NR)) begin
        // Ascending scan so the highest-numbered writer wins.
        for (int b = 0; b < NW; b++) begin
          if (w_bank_we[b] && (w_bank_addr[b] == w_rd_addr[c])) begin
            w_rd_val[c] = w_bank_data[b];
          end
        end
      end
      if ((r_state == S_INIT) || is_zero_idx(w_rd_addr[c])) begin
        w_rd_val[c] = '0;
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    for (int c = 0; c < NR; c++) begin
      rd_data_o[c*DATA_WIDTH +: DATA_WIDTH] = w_rd_val[c];
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state     <= S_INIT;
      r_init_cnt  <= '0;
      r_dbg_ack   <= 1'b0;
      r_dbg_rdata <= '0;
      r_wr_drop   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_lvt[i] <= '0;
      end
    end else begin
      r_dbg_ack <= w_dbg_fire;
      r_wr_drop <= w_wr_drop;
      if (w_dbg_rd) begin
        r_dbg_rdata <= w_rd_val[NR];
      end

      // Later iterations override earlier ones: highest bank owns the entry.
      for (int b = 0; b < NW; b++) begin
        if (w_bank_we[b]) begin
          r_lvt[w_bank_addr[b]] <= LW'(b);
        end
      end

      case (r_state)
        S_INIT: begin
          r_init_cnt <= r_init_cnt + 1'b1;
          if (r_init_cnt == IW'(DEPTH - 1)) begin
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

  assign init_done_o = (r_state == S_RUN);
  assign dbg_ack_o   = r_dbg_ack;
  assign dbg_rdata_o = r_dbg_rdata;
  assign wr_drop_o   = r_wr_drop;

endmodule

// File: tb/tb_prv664_regfile_lvt.sv
// -----------------------------------------------------------------------------
// Testbench for prv664_regfile_lvt. Two instances share all inputs: one with
// write-to-read bypass disabled, one with it enabled. A behavioural model keeps
// the architectural register values in a plain array and predicts every
// output each cycle; directed sections add literal expectations.
// -----------------------------------------------------------------------------
module tb_prv664_regfile_lvt;

  localparam int DW = 64;
  localparam int IW = 5;
  localparam int NR = 4;
  localparam int NW = 2;

  logic                clk;
  logic                arst;
  logic [NR*IW-1:0]    rd_index;
  logic [NR*DW-1:0]    rd_nb, rd_by;
  logic [NW-1:0]       wr_valid;
  logic [NW*IW-1:0]    wr_index;
  logic [NW*DW-1:0]    wr_data;
  logic                halted, dbg_req, dbg_we;
  logic [IW-1:0]       dbg_index;
  logic [DW-1:0]       dbg_wdata;
  logic                done_nb, ack_nb, drop_nb;
  logic                done_by, ack_by, drop_by;
  logic [DW-1:0]       rdata_nb, rdata_by;

  int n_checks = 0;
  int n_pass   = 0;

  prv664_regfile_lvt #(.BYPASS(0)) dut_nb (
    .clk_i(clk), .arst_i(arst), .rd_index_i(rd_index), .rd_data_o(rd_nb),
    .wr_valid_i(wr_valid), .wr_index_i(wr_index), .wr_data_i(wr_data),
    .init_done_o(done_nb), .halted_i(halted), .dbg_req_i(dbg_req),
    .dbg_we_i(dbg_we), .dbg_index_i(dbg_index), .dbg_wdata_i(dbg_wdata),
    .dbg_ack_o(ack_nb), .dbg_rdata_o(rdata_nb), .wr_drop_o(drop_nb)
  );

  prv664_regfile_lvt #(.BYPASS(1)) dut_by (
    .clk_i(clk), .arst_i(arst), .rd_index_i(rd_index), .rd_data_o(rd_by),
    .wr_valid_i(wr_valid), .wr_index_i(wr_index), .wr_data_i(wr_data),
    .init_done_o(done_by), .halted_i(halted), .dbg_req_i(dbg_req),
    .dbg_we_i(dbg_we), .dbg_index_i(dbg_index), .dbg_wdata_i(dbg_wdata),
    .dbg_ack_o(ack_by), .dbg_rdata_o(rdata_by), .wr_drop_o(drop_by)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_reg [32];
  bit            m_run;
  int            m_cnt;
  bit            m_ack;
  logic [DW-1:0] m_rdata;
  bit            m_drop;

  bit            e_we  [NW];
  logic [IW-1:0] e_idx [NW];
  logic [DW-1:0] e_dat [NW];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_run = 0; m_cnt = 0; m_ack = 0; m_rdata = '0; m_drop = 0;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
  endfunction

  function automatic bit dbg_fire();
    return m_run && halted && dbg_req && !m_ack;
  endfunction

  // Writes that actually land this cycle, in port order.
  function automatic void calc_eff();
    for (int w = 0; w < NW; w++) begin
      e_idx[w] = wr_index[w*IW +: IW];
      e_dat[w] = wr_data[w*DW +: DW];
      e_we[w]  = m_run && wr_valid[w] && (e_idx[w] != 0);
    end
    if (dbg_fire() && dbg_we) begin
      e_we[0]  = (dbg_index != 0);
      e_idx[0] = dbg_index;
      e_dat[0] = dbg_wdata;
    end
  endfunction

  function automatic logic [DW-1:0] exp_rd(input bit byp, input logic [IW-1:0] idx);
    logic [DW-1:0] v;
    if (!m_run || idx == 0) return '0;
    v = m_reg[idx];
    if (byp) begin
      calc_eff();
      for (int w = 0; w < NW; w++) if (e_we[w] && e_idx[w] == idx) v = e_dat[w];
    end
    return v;
  endfunction

  function automatic void model_step();
    bit fire;
    fire = dbg_fire();
    calc_eff();
    if (fire && !dbg_we) m_rdata = (dbg_index == 0) ? '0 : m_reg[dbg_index];
    m_drop = (!m_run && (|wr_valid)) ||
             (fire && dbg_we && wr_valid[0] && (wr_index[IW-1:0] != 0));
    for (int w = 0; w < NW; w++) if (e_we[w]) m_reg[e_idx[w]] = e_dat[w];
    if (!m_run) begin
      m_cnt++;
      if (m_cnt == 32) m_run = 1;
    end
    m_ack = fire;
  endfunction

  task automatic compare();
    logic [IW-1:0] idx;
    for (int r = 0; r < NR; r++) begin
      idx = rd_index[r*IW +: IW];
      check($sformatf("rd_nobyp[%0d] idx %0d", r, idx), rd_nb[r*DW +: DW], exp_rd(1'b0, idx));
      check($sformatf("rd_byp[%0d] idx %0d", r, idx), rd_by[r*DW +: DW], exp_rd(1'b1, idx));
    end
    check("init_done", done_nb, m_run);
    check("dbg_ack", ack_nb, m_ack);
    check("dbg_rdata", rdata_nb, m_rdata);
    check("wr_drop", drop_nb, m_drop);
    check("init_done_byp", done_by, m_run);
    check("dbg_ack_byp", ack_by, m_ack);
  endtask

  // One cycle: inputs were set after a negedge; compare, clock, advance model.
  task automatic tick();
    if (arst) model_reset();
    #1;
    compare();
    @(posedge clk);
    if (!arst) model_step();
    @(negedge clk);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    wr_valid = '0; wr_index = '0; wr_data = '0; rd_index = '0;
    halted = 0; dbg_req = 0; dbg_we = 0; dbg_index = '0; dbg_wdata = '0;
  endtask

  task automatic rand_commit(input int max_idx);
    for (int w = 0; w < NW; w++) begin
      wr_index[w*IW +: IW] = IW'($urandom_range(0, max_idx));
      wr_data[w*DW +: DW]  = {$urandom, $urandom};
    end
    for (int r = 0; r < NR; r++) rd_index[r*IW +: IW] = IW'($urandom_range(0, max_idx));
  endtask

  // Counts cycles from here until init_done is observed (bounded).
  task automatic wait_init(output int rise);
    rise = -1;
    for (int i = 0; i < 100 && rise < 0; i++) begin
      if (done_nb) rise = i;
      else begin
        rand_commit(31);
        tick();
      end
    end
  endtask

  task automatic dbg_access(input bit we, input logic [IW-1:0] idx,
                            input logic [DW-1:0] d, output int lat);
    halted = 1; dbg_req = 1; dbg_we = we; dbg_index = idx; dbg_wdata = d;
    lat = -1;
    for (int i = 1; i <= 10 && lat < 0; i++) begin
      tick();
      if (ack_nb) lat = i;
    end
    dbg_req = 0;
  endtask

  initial begin
    int rise;
    int lat;

    idle();
    arst = 1;
    @(negedge clk);
    tick();
    tick();
    check("rst_init_done", done_nb, 0);
    check("rst_dbg_ack", ack_nb, 0);
    check("rst_wr_drop", drop_nb, 0);

    // Zeroing with commit writes hammering every cycle.
    arst = 0;
    wr_valid = '1;
    wait_init(rise);
    check("init_cycles", 64'(rise), 64'd32);
    wr_valid = '0;

    // Dual-write conflict: highest port wins.
    wr_valid = 2'b11;
    wr_index = {5'd5, 5'd5};
    wr_data  = {64'hBBBB, 64'hAAAA};
    rd_index = {4{5'd5}};
    tick();
    for (int r = 0; r < NR; r++) check("dual_hi_wins", rd_nb[r*DW +: DW], 64'hBBBB);
    wr_valid = 2'b01;
    wr_data[DW-1:0] = 64'hCCCC;
    tick();
    wr_valid = '0;
    #1;
    for (int r = 0; r < NR; r++) check("port0_rewrite", rd_nb[r*DW +: DW], 64'hCCCC);

    // Bypass: clear idx 7, then write DEAD while reading it.
    wr_valid = 2'b10;
    wr_index = {5'd7, 5'd0};
    wr_data  = '0;
    tick();
    wr_valid = 2'b01;
    wr_index = {5'd0, 5'd7};
    wr_data  = {64'h0, 64'hDEAD};
    rd_index = {4{5'd7}};
    #1;
    for (int r = 0; r < NR; r++) begin
      check("bypass_on", rd_by[r*DW +: DW], 64'hDEAD);
      check("bypass_off", rd_nb[r*DW +: DW], 64'h0);
    end
    tick();
    wr_valid = '0;
    #1;
    check("after_bypass_write", rd_nb[DW-1:0], 64'hDEAD);

    // Debug write displacing commit port 0.
    wr_valid = 2'b10;
    wr_index = {5'd9, 5'd0};
    wr_data  = {64'h99, 64'h0};
    tick();
    wr_valid = 2'b01;
    wr_index = {5'd0, 5'd9};
    wr_data  = {64'h0, 64'hEEEE};
    halted = 1; dbg_req = 1; dbg_we = 1; dbg_index = 5'd3; dbg_wdata = 64'h55;
    rd_index = {5'd3, 5'd9, 5'd3, 5'd9};
    tick();
    wr_valid = '0;
    #1;
    check("dbgw_ack", ack_nb, 1);
    check("dbgw_drop", drop_nb, 1);
    check("dbgw_idx9_kept", rd_nb[DW-1:0], 64'h99);
    check("dbgw_idx3", rd_nb[DW +: DW], 64'h55);
    dbg_req = 0;
    tick();
    dbg_access(1'b0, 5'd3, '0, lat);
    check("dbgr_latency", 64'(lat), 64'd1);
    check("dbgr_data", rdata_nb, 64'h55);

    // Zero register on every port and the debug port.
    wr_valid = 2'b11;
    wr_index = '0;
    wr_data  = {64'h1234, 64'h1234};
    rd_index = '0;
    tick();
    for (int r = 0; r < NR; r++) begin
      check("zero_reg_nb", rd_nb[r*DW +: DW], 64'h0);
      check("zero_reg_by", rd_by[r*DW +: DW], 64'h0);
    end
    check("zero_reg_nodrop", drop_nb, 0);
    wr_valid = '0;
    dbg_access(1'b0, 5'd0, '0, lat);
    check("zero_reg_dbg", rdata_nb, 64'h0);

    // Reset in the cycle after a debug read is sampled.
    halted = 1; dbg_req = 1; dbg_we = 0; dbg_index = 5'd3;
    tick();
    arst = 1;
    #1;
    check("rst_mid_ack", ack_nb, 0);
    check("rst_mid_done", done_nb, 0);
    tick();
    tick();
    arst = 0;
    wr_valid = 2'b11;
    wait_init(rise);
    check("reinit_cycles", 64'(rise), 64'd32);
    dbg_req = 0;
    wr_valid = '0;
    dbg_access(1'b0, 5'd3, '0, lat);
    check("reinit_cleared", rdata_nb, 64'h0);

    // Randomized traffic with the debug handshake and rare resets.
    idle();
    for (int i = 0; i < 1500; i++) begin
      if (arst) arst = 0;
      else if ($urandom_range(0, 599) == 0) arst = 1;
      wr_valid = NW'($urandom);
      rand_commit(($urandom_range(0, 1) == 0) ? 7 : 31);
      halted = ($urandom_range(0, 3) != 0);
      if (m_ack) dbg_req = 0;
      else if (!dbg_req && $urandom_range(0, 2) == 0) begin
        dbg_req   = 1;
        dbg_we    = $urandom_range(0, 1) == 1;
        dbg_index = IW'($urandom_range(0, 7));
        dbg_wdata = {$urandom, $urandom};
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
